// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt/ERET sequencer: IDLE -> FLUSH -> REDIRECT -> IDLE.
// Optional macro CP0_EXC_CTRL_IRQ_SYNC_EN adds a 2-flop synchronizer on int_req.
//   state      | meaning
//   S_IDLE     | waiting for exc_req / pending interrupt / eret
//   S_FLUSH    | EPC/Cause write (exc/irq), EXL update, target latched
//   S_REDIRECT | redirect held until redirect_ack
module cp0_exc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] status,
  input  logic [7:0]  int_req,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic [31:0] irq_pc,
  input  logic        eret,
  input  logic [31:0] epc_in,
  input  logic        redirect_ack,
  output logic        flush,
  output logic        epc_we,
  output logic [31:0] epc_wd,
  output logic        cause_we,
  output logic [31:0] cause_wd,
  output logic        exl_next,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  w_irq;
  logic        w_pending;
  logic        w_take;
  logic        w_sel_eret;
  logic        r_eret;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_redirect_pc;

`ifdef CP0_EXC_CTRL_IRQ_SYNC_EN
  logic [7:0] r_irq_s1;
  logic [7:0] r_irq_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_s1 <= 8'h00;
      r_irq_s2 <= 8'h00;
    end else begin
      r_irq_s1 <= int_req;
      r_irq_s2 <= r_irq_s1;
    end
  end

  assign w_irq = r_irq_s2;
`else
  assign w_irq = int_req;
`endif

  assign w_pending  = (|(w_irq & status[15:8])) & status[0] & ~status[1] & ~status[2];
  assign w_take     = exc_req | w_pending | eret;
  assign w_sel_eret = ~exc_req & ~w_pending & eret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_take) w_next = S_FLUSH;
      S_FLUSH:    w_next = S_REDIRECT;
      S_REDIRECT: if (redirect_ack) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Winner is captured in the IDLE cycle; later requests cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eret        <= 1'b0;
      r_epc         <= 32'h0;
      r_cause       <= 32'h0;
      r_redirect_pc <= 32'h0;
    end else begin
      if (r_state == S_IDLE && w_take) begin
        r_eret  <= w_sel_eret;
        r_epc   <= exc_req ? (exc_bd ? exc_pc - 32'd4 : exc_pc) : irq_pc;
        r_cause <= {exc_req & exc_bd, 15'b0, w_irq, 1'b0,
                    exc_req ? exc_code : 5'd0, 2'b00};
      end
      if (r_state == S_FLUSH) begin
        if (r_eret)          r_redirect_pc <= epc_in;
        else if (status[22]) r_redirect_pc <= 32'hBFC0_0380;
        else                 r_redirect_pc <= 32'h8000_0180;
      end
    end
  end

  always_comb begin
    flush       = 1'b0;
    epc_we      = 1'b0;
    epc_wd      = 32'h0;
    cause_we    = 1'b0;
    cause_wd    = 32'h0;
    exl_next    = status[1];
    redirect    = 1'b0;
    busy        = 1'b0;
    redirect_pc = r_redirect_pc;
    case (r_state)
      S_IDLE: flush = w_take & ~rst;
      S_FLUSH: begin
        busy     = 1'b1;
        epc_we   = ~r_eret;
        cause_we = ~r_eret;
        epc_wd   = r_eret ? 32'h0 : r_epc;
        cause_wd = r_eret ? 32'h0 : r_cause;
        exl_next = ~r_eret;
      end
      S_REDIRECT: begin
        busy     = 1'b1;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: directed cases plus randomized requests.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] status;
  logic [7:0]  int_req;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_pc;
  logic [31:0] irq_pc;
  logic        eret;
  logic [31:0] epc_in;
  logic        redirect_ack;
  logic        flush;
  logic        epc_we;
  logic [31:0] epc_wd;
  logic        cause_we;
  logic [31:0] cause_wd;
  logic        exl_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .status(status), .int_req(int_req),
    .exc_req(exc_req), .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc),
    .irq_pc(irq_pc), .eret(eret), .epc_in(epc_in), .redirect_ack(redirect_ack),
    .flush(flush), .epc_we(epc_we), .epc_wd(epc_wd), .cause_we(cause_we),
    .cause_wd(cause_wd), .exl_next(exl_next), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        exl;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: decide winner from the architectural rules, build expected writes.
  function automatic exp_t model(input logic [31:0] st, input logic [7:0] irq,
                                 input logic er, input logic [4:0] code,
                                 input logic bd, input logic [31:0] pc,
                                 input logic [31:0] ipc, input logic ert,
                                 input logic [31:0] epc, output bit take);
    exp_t e;
    bit irq_pend;
    irq_pend = ((irq & st[15:8]) != 0) && st[0] && !st[1] && !st[2];
    take = er || irq_pend || ert;
    e.wr = er || irq_pend;
    e.exl = e.wr;
    if (er) begin
      e.epc   = bd ? pc - 4 : pc;
      e.cause = (32'(bd) << 31) | (32'(irq) << 8) | (32'(code) << 2);
    end else begin
      e.epc   = ipc;
      e.cause = 32'(irq) << 8;
    end
    if (!e.wr)      e.target = epc;
    else if (st[22]) e.target = 32'hBFC00380;
    else             e.target = 32'h80000180;
    return e;
  endfunction

  // Monitor: pops one expectation per FLUSH cycle, checks the redirect phase.
  initial begin
    exp_t cur;
    bit   have = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && !done) begin
        if (busy && !redirect) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_flush_cycle: got busy=1 expected no sequence");
          end else begin
            cur  = sb.pop_front();
            have = 1;
            chk("epc_we", 32'(epc_we), 32'(cur.wr));
            chk("cause_we", 32'(cause_we), 32'(cur.wr));
            chk("exl_next_flush", 32'(exl_next), 32'(cur.exl));
            if (cur.wr) begin
              chk("epc_wd", epc_wd, cur.epc);
              chk("cause_wd", cause_wd, cur.cause);
            end
          end
        end else if (redirect) begin
          if (have) chk("redirect_pc", redirect_pc, cur.target);
          else begin
            n_checks++;
            n_fail++;
            $display("FAIL redirect_without_flush: got redirect=1 expected 0");
          end
        end else begin
          chk("exl_next_idle", 32'(exl_next), 32'(status[1]));
          chk("idle_we", 32'({epc_we, cause_we}), 32'h0);
        end
      end
    end
  end

  task automatic clear_req();
    exc_req = 0;
    eret    = 0;
    int_req = 8'h00;
  endtask

  // One request: hold keeps requests asserted while busy; rst_mid resets in REDIRECT.
  task automatic txn(input logic [31:0] st, input logic [7:0] irq, input logic er,
                     input logic [4:0] code, input logic bd, input logic [31:0] pc,
                     input logic [31:0] ipc, input logic ert, input logic [31:0] epc,
                     input int ack_dly, input bit hold, input bit rst_mid);
    exp_t e;
    bit   take;
    @(negedge clk);
    status = st; int_req = irq; exc_req = er; exc_code = code; exc_bd = bd;
    exc_pc = pc; irq_pc = ipc; eret = ert; epc_in = epc;
    e = model(st, irq, er, code, bd, pc, ipc, ert, epc, take);
    #1;
    chk("flush_idle", 32'(flush), 32'(take));
    if (take) sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      exc_pc = ~pc;
      irq_pc = ~ipc;
    end else clear_req();
    if (!take) return;
    #1;
    chk("flush_in_flush", 32'(flush), 32'h0);
    @(negedge clk);
    #1;
    chk("redirect_latency", 32'(redirect), 32'h1);
    if (rst_mid) begin
      rst = 1;
      #1;
      chk("rst_redirect", 32'(redirect), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_we", 32'({epc_we, cause_we, flush}), 32'h0);
      @(negedge clk);
      rst = 0;
      clear_req();
      #1;
      chk("busy_after_rst", 32'(busy), 32'h0);
      @(negedge clk);
      #1;
      chk("idle_after_rst", 32'(busy), 32'h0);
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      #1;
      chk("redirect_hold", 32'(redirect), 32'h1);
      if (hold) chk("no_flush_busy", 32'(flush), 32'h0);
    end
    @(negedge clk);
    redirect_ack = 1;
    @(negedge clk);
    redirect_ack = 0;
    clear_req();
    #1;
    if (busy) begin
      chk("return_idle", 32'(busy), 32'h0);
      rst = 1;
      @(negedge clk);
      rst = 0;
    end else chk("return_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1; status = 32'h0; clear_req(); exc_code = 0; exc_bd = 0;
    exc_pc = 0; irq_pc = 0; epc_in = 0; redirect_ack = 0;
    #1;
    chk("rst_outputs", 32'({flush, epc_we, cause_we, redirect, busy}), 32'h0);
    chk("rst_redirect_pc0", redirect_pc, 32'h0);
    chk("rst_data", epc_wd | cause_wd, 32'h0);
    status = 32'h2;
    #1;
    chk("rst_exl_follow", 32'(exl_next), 32'h1);
    repeat (2) @(negedge clk);
    rst = 0;

    txn(32'h0040FF01, 8'h00, 1, 5'h0A, 0, 32'h00400020, 32'h0, 0, 32'h0, 0, 0, 0);
    txn(32'h0000FF01, 8'h00, 1, 5'h0C, 1, 32'h00400024, 32'h0, 0, 32'h0, 1, 0, 0);
    txn(32'h00000401, 8'h04, 0, 5'h00, 0, 32'h0, 32'h00400800, 0, 32'h0, 0, 0, 0);
    txn(32'h00000400, 8'h04, 0, 5'h00, 0, 32'h0, 32'h00400800, 0, 32'h0, 0, 0, 0);
    txn(32'h00000403, 8'h04, 0, 5'h00, 0, 32'h0, 32'h00400800, 0, 32'h0, 0, 0, 0);
    txn(32'h0000FF01, 8'hFF, 1, 5'h05, 0, 32'h00400040, 32'h00400900, 1, 32'h00400100, 3, 1, 0);
    txn(32'h00000002, 8'h00, 0, 5'h00, 0, 32'h0, 32'h0, 1, 32'h00400100, 2, 0, 0);
    txn(32'h0040FF01, 8'h00, 1, 5'h0A, 0, 32'h00400020, 32'h0, 0, 32'h0, 2, 0, 1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] st;
      st = $urandom;
      st[1] = ($urandom_range(0, 3) == 0);
      st[2] = ($urandom_range(0, 5) == 0);
      txn(st, 8'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom), 1'($urandom),
          $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC, ($urandom_range(0, 2) == 0),
          $urandom & 32'hFFFFFFFC, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
